// File: rtl/program_loader_if.sv
// Boot-path bundle: UART RX/TX bytes in and out, plus the program-load port into inst_fetch.
// The master modport is the loader; the slave modport is its UART/inst_fetch surroundings.
interface program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       load_start;
    logic [7:0] load_data;
    logic       load_valid;
    logic       load_end;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       loading;
    logic       boot_done;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output load_start, load_data, load_valid, load_end,
               tx_data, tx_valid, loading, boot_done
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  load_start, load_data, load_valid, load_end,
               tx_data, tx_valid, loading, boot_done
    );
endinterface

// File: rtl/program_loader.sv
// Parses a big-endian word-count header from UART bytes, streams 4N program bytes to
// inst_fetch framed by start/end pulses, then reports 0xAA (loaded) or 0xEE (rejected) back.
module program_loader #(
    parameter int INST_MEM_WIDTH = 2
) (
    input  logic              CLK,
    input  logic              reset,
    program_loader_if.master  bus
);
    localparam int          CW        = INST_MEM_WIDTH + 2;
    localparam logic [31:0] MAX_WORDS = 32'd1 << INST_MEM_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_START, S_DATA, S_END, S_ACK, S_DONE, S_ERR
    } state_t;

    state_t        r_state;
    logic [23:0]   r_n;
    logic [1:0]    r_hdr_cnt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_last;

    logic          r_load_start;
    logic [7:0]    r_load_data;
    logic          r_load_valid;
    logic          r_load_end;
    logic [7:0]    r_tx_data;
    logic          r_tx_valid;
    logic          r_loading;
    logic          r_boot_done;

    logic [31:0]   w_n;
    logic          w_n_ok;
    logic [CW-1:0] w_last;

    // Full word count as it stands when the 4th header byte is on rx_data.
    assign w_n    = {r_n, bus.rx_data};
    assign w_n_ok = (w_n != 32'd0) && (w_n <= MAX_WORDS);
    // Index of the final byte, 4N-1; wraps cleanly to all-ones when N fills the memory.
    assign w_last = {w_n[INST_MEM_WIDTH-1:0], 2'b00} - CW'(1);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_hdr_cnt    <= '0;
            r_cnt        <= '0;
            r_last       <= '0;
            r_load_start <= 1'b0;
            r_load_data  <= 8'h00;
            r_load_valid <= 1'b0;
            r_load_end   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_loading    <= 1'b0;
            r_boot_done  <= 1'b0;
        end else begin
            r_load_start <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_end   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        r_n       <= {16'd0, bus.rx_data};
                        r_hdr_cnt <= 2'd1;
                        r_loading <= 1'b1;
                        r_state   <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (bus.rx_valid) begin
                        r_n       <= w_n[23:0];
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                        if (r_hdr_cnt == 2'd3) begin
                            if (w_n_ok) begin
                                r_last       <= w_last;
                                r_cnt        <= '0;
                                r_load_start <= 1'b1;
                                r_state      <= S_START;
                            end else begin
                                r_loading  <= 1'b0;
                                r_tx_data  <= 8'hEE;
                                r_tx_valid <= 1'b1;
                                r_state    <= S_ERR;
                            end
                        end
                    end
                end
                // A byte landing during the start pulse is data byte 0, so START shares DATA's path.
                S_START, S_DATA: begin
                    r_state <= S_DATA;
                    if (bus.rx_valid) begin
                        r_load_data  <= bus.rx_data;
                        r_load_valid <= 1'b1;
                        r_cnt        <= r_cnt + CW'(1);
                        if (r_cnt == r_last)
                            r_state <= S_END;
                    end
                end
                S_END: begin
                    r_load_end <= 1'b1;
                    r_state    <= S_ACK;
                end
                S_ACK: begin
                    if (!r_tx_valid) begin
                        r_loading  <= 1'b0;
                        r_tx_data  <= 8'hAA;
                        r_tx_valid <= 1'b1;
                    end else if (bus.tx_ready) begin
                        r_tx_valid  <= 1'b0;
                        r_boot_done <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_ERR: begin
                    if (bus.tx_ready) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.load_start = r_load_start;
    assign bus.load_data  = r_load_data;
    assign bus.load_valid = r_load_valid;
    assign bus.load_end   = r_load_end;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.loading    = r_loading;
    assign bus.boot_done  = r_boot_done;
endmodule

// File: tb/tb_program_loader.sv
// Directed-plus-random bench for program_loader: records every output per cycle and checks it
// against a transaction-level model of the expected load stream and status handshake.
module tb_program_loader;
    localparam int W    = 2;
    localparam int MAXC = 16384;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    program_loader_if bus();

    program_loader #(.INST_MEM_WIDTH(W)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Per-cycle history of the outputs, sampled mid-cycle.
    logic       h_start [MAXC];
    logic       h_valid [MAXC];
    logic       h_end   [MAXC];
    logic       h_txv   [MAXC];
    logic       h_load  [MAXC];
    logic       h_done  [MAXC];
    logic [7:0] h_data  [MAXC];

    always @(negedge CLK)
        if (cyc < MAXC) begin
            h_start[cyc] <= bus.load_start;
            h_valid[cyc] <= bus.load_valid;
            h_end[cyc]   <= bus.load_end;
            h_txv[cyc]   <= bus.tx_valid;
            h_load[cyc]  <= bus.loading;
            h_done[cyc]  <= bus.boot_done;
            h_data[cyc]  <= bus.load_data;
        end

    logic [7:0] fixed_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap(input int gm);
        repeat ($urandom_range(0, gm)) tick();
    endtask

    task automatic send(input logic [7:0] b, output int c);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        c = cyc;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        tick();
        chk({tag, " outputs after reset"},
            32'({bus.load_start, bus.load_data, bus.load_valid, bus.load_end,
                 bus.tx_data, bus.tx_valid, bus.loading, bus.boot_done}), 32'd0);
        reset = 1'b1;
        tick();
    endtask

    task automatic count_ev(input int c_from, input int c_to,
                            output int ns, output int nv, output int ne,
                            output int nt, output int nx, output int nd);
        ns = 0; nv = 0; ne = 0; nt = 0; nx = 0; nd = 0;
        for (int c = c_from; c < c_to; c++) begin
            ns += int'(h_start[c]);
            nv += int'(h_valid[c]);
            ne += int'(h_end[c]);
            nt += int'(h_txv[c]);
            nd += int'(h_done[c]);
            if ((int'(h_start[c]) + int'(h_valid[c]) + int'(h_end[c])) > 1) nx++;
        end
    endtask

    // Send one image and check every observable consequence against the format rules.
    task automatic run_image(input string tag, input logic [31:0] n, input int gap_max,
                             input bit b2b, input int txd);
        int c, c0, c_hdr1, c_hdr4, c_last, c_txv, tmo;
        int ns, nv, ne, nt, nx, nd, vi, vbad;
        bit ok, held;
        logic [7:0] b, txd0;
        int exp_c[$];
        logic [7:0] exp_d[$];
        ok = (n != 32'd0) && (n <= (32'd1 << W));
        c0 = cyc;
        c  = 0;
        c_hdr1 = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0 && !b2b) gap(gap_max);
            send(n[31-8*i -: 8], c);
            if (i == 0) c_hdr1 = c;
        end
        c_hdr4 = c;
        if (ok)
            for (int i = 0; i < 4 * int'(n); i++) begin
                if (!b2b) gap(gap_max);
                b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
                send(b, c);
                exp_c.push_back(c + 1);
                exp_d.push_back(b);
            end
        c_last = c;
        tmo = 0;
        while (bus.tx_valid !== 1'b1 && tmo < 40) begin
            tick();
            tmo++;
        end
        chk({tag, " tx_valid arrives"}, 32'(tmo < 40), 32'd1);
        c_txv = cyc;
        chk({tag, " tx_valid rise cycle"}, c_txv, ok ? c_last + 3 : c_hdr4 + 1);
        chk({tag, " tx_data"}, 32'(bus.tx_data), ok ? 32'hAA : 32'hEE);
        txd0 = bus.tx_data;
        held = 1'b1;
        repeat (txd) begin
            tick();
            held &= (bus.tx_valid === 1'b1) && (bus.tx_data === txd0);
        end
        if (txd > 0) chk({tag, " tx held under backpressure"}, 32'(held), 32'd1);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk({tag, " tx_valid after handshake"}, 32'(bus.tx_valid), 32'd0);
        chk({tag, " boot_done after handshake"}, 32'(bus.boot_done), 32'(ok));
        tick();
        count_ev(c0, cyc, ns, nv, ne, nt, nx, nd);
        chk({tag, " load_start count"}, ns, ok ? 1 : 0);
        chk({tag, " load_end count"}, ne, ok ? 1 : 0);
        chk({tag, " load_valid count"}, nv, exp_c.size());
        chk({tag, " pulse overlap cycles"}, nx, 0);
        vi = 0;
        vbad = 0;
        for (int cc = c0; cc < cyc; cc++)
            if (h_valid[cc]) begin
                if (vi >= exp_c.size() || exp_c[vi] != cc || exp_d[vi] !== h_data[cc]) vbad++;
                vi++;
            end
        chk({tag, " data stream errors"}, vbad, 0);
        chk({tag, " loading before header"}, 32'(h_load[c_hdr1]), 32'd0);
        chk({tag, " loading after header byte"}, 32'(h_load[c_hdr1 + 1]), 32'd1);
        if (ok) begin
            chk({tag, " load_start timing"}, 32'(h_start[c_hdr4 + 1]), 32'd1);
            chk({tag, " load_end timing"}, 32'(h_end[c_last + 2]), 32'd1);
            chk({tag, " loading during load_end"}, 32'(h_load[c_last + 2]), 32'd1);
            chk({tag, " loading after load_end"}, 32'(h_load[c_last + 3]), 32'd0);
        end else begin
            chk({tag, " loading on ERR entry"}, 32'(h_load[c_hdr4 + 1]), 32'd0);
        end
    endtask

    initial begin
        int c, c0, ns, nv, ne, nt, nx, nd;
        logic [31:0] n;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        tick();
        do_reset("init");

        fixed_q = '{8'h04, 8'h10, 8'hC2, 8'h00};
        run_image("nominal", 32'd1, 3, 1'b0, 0);

        c0 = cyc;
        repeat (6) begin
            gap(2);
            send(8'($urandom), c);
        end
        tick();
        count_ev(c0, cyc, ns, nv, ne, nt, nx, nd);
        chk("done load pulses", ns + nv + ne, 0);
        chk("done tx_valid", nt, 0);
        chk("done boot_done held", nd, cyc - c0);

        do_reset("pre-reject");
        run_image("reject5", 32'd5, 2, 1'b0, 0);
        run_image("reject0", 32'd0, 2, 1'b0, 2);
        run_image("after-reject", 32'($urandom_range(1, 4)), 2, 1'b0, 10);

        do_reset("pre-b2b");
        run_image("b2b-full", 32'd4, 0, 1'b1, 3);

        do_reset("pre-midload");
        for (int i = 0; i < 4; i++) send((i == 3) ? 8'h01 : 8'h00, c);
        send(8'($urandom), c);
        send(8'($urandom), c);
        c0 = cyc;
        do_reset("midload");
        repeat (4) tick();
        count_ev(c0, cyc, ns, nv, ne, nt, nx, nd);
        chk("midload no load_end", ne, 0);
        run_image("post-midload", 32'($urandom_range(1, 4)), 2, 1'b0, 1);

        for (int k = 0; k < 4; k++) begin
            do_reset("rand");
            n = 32'($urandom_range(0, 6));
            run_image("rand", n, 3, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
            if (n == 32'd0 || n > 32'd4)
                run_image("rand-retry", 32'($urandom_range(1, 4)), 3, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/program_loader.md
# program_loader

Front end of the boot path: takes raw bytes from the UART receiver, parses a length-prefixed program image, and drives the instruction-fetch stage's program-load port with a start pulse, a per-byte data/valid stream, and an end pulse. When the load completes it reports the result to the host through the UART transmitter. It sits between the UART RX/TX pair and `inst_fetch`, and `inst_fetch` samples its `load_*` outputs directly.

## Interface
- `INST_MEM_WIDTH`, default 2: instruction-memory address width. Capacity is 2^INST_MEM_WIDTH 32-bit words.

- `CLK`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset. `reset`=0 at a rising edge resets the block.
- `rx_data`  in  8  byte from the UART receiver.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid in that cycle.
- `load_start`  out  1  one-cycle pulse; tells `inst_fetch` to begin a load.
- `load_data`  out  8  registered program byte.
- `load_valid`  out  1  one-cycle strobe accompanying `load_data`.
- `load_end`  out  1  one-cycle pulse; load complete.
- `tx_data`  out  8  status byte to the UART transmitter.
- `tx_valid`  out  1  held high until the byte is accepted.
- `tx_ready`  in  1  transmitter ready. The byte is taken in any cycle where `tx_valid` and `tx_ready` are both 1.
- `loading`  out  1  high from the first header byte through `load_end`.
- `boot_done`  out  1  sticky success flag.

## Operation
- Image format:
  - 4 header bytes giving word count N, big-endian (first byte = N[31:24]).
  - Then exactly 4N program bytes, forwarded unchanged and in received order. `inst_fetch` packs them, e.g. 04 10 C2 00 becomes word 0x0410C200.
- States:
  - IDLE: the first `rx_valid` captures N[31:24] and moves to HDR.
  - HDR: captures the remaining 3 header bytes. On the 4th byte:
    - if N==0 or N > 2^INST_MEM_WIDTH, go to ERR;
    - otherwise go to START.
  - START: asserts `load_start` for exactly one cycle, then goes to DATA.
  - DATA: every `rx_valid` is forwarded. After the 4N-th byte, go to END.
  - END: asserts `load_end` for one cycle, then goes to ACK.
  - ACK: `tx_data`=0xAA and `tx_valid`=1 until handshake, then go to DONE.
  - DONE: `boot_done`=1; all `rx_valid` is ignored. Left only by reset.
  - ERR: `tx_data`=0xEE and `tx_valid`=1 until handshake, then go to IDLE. No `load_*` pulse is ever issued for a rejected image.
- Byte counter is INST_MEM_WIDTH+2 bits, compared against 4N. Overflow is impossible after the range check.
- An `rx_valid` arriving while in START is accepted as data byte 0. It is forwarded in the cycle after `load_start`.
- `rx_valid` in END, ACK, ERR or DONE is dropped.
- Reset mid-load:
  - all outputs go to 0, the state goes to IDLE, and the counter and N are cleared;
  - no `load_end` is emitted. `inst_fetch` is expected to be reset by the same signal.

## Timing
- Reset values: `load_start`=0, `load_data`=0x00, `load_valid`=0, `load_end`=0, `tx_data`=0x00, `tx_valid`=0, `loading`=0, `boot_done`=0.
- Header byte 4 at cycle t: `load_start`=1 at t+1 only.
- Data byte accepted at cycle t: `load_data`/`load_valid` registered at t+1, giving 1-cycle latency. `load_valid` never lasts more than one cycle per byte.
- Last data byte at t:
  - its `load_valid` is at t+1;
  - `load_end`=1 at t+2;
  - `tx_valid`=1 from t+3.
- `loading`:
  - rises the cycle after the first header byte;
  - falls the cycle after `load_end`;
  - in the reject path, falls when entering ERR.
- Handshake in cycle h (`tx_valid` and `tx_ready` both 1): `tx_valid`=0 at h+1. `boot_done`=1 from h+1 (success path only).
- `load_start`, `load_valid` and `load_end` are mutually exclusive in any cycle.
- `rx_valid` strobes may be back-to-back. Every one in HDR, START or DATA is consumed.

## Test plan
- **Nominal load.** INST_MEM_WIDTH=2; bytes 00 00 00 01 04 10 C2 00 with gaps; `tx_ready`=1. Required:
  - `load_start` pulses once;
  - `load_valid` pulses 4 times with data 04, 10, C2, 00;
  - `load_end` 1 cycle after the last `load_valid`;
  - `tx_data`=0xAA handshaken;
  - `boot_done`=1.
- **Back-to-back / capacity.** N=4 (full memory); 16 data bytes on consecutive cycles, with the first arriving during START. Required: 16 `load_valid` pulses, each 1 cycle after its `rx_valid`, and exactly one `load_end`.
- **Reject.** Header 00 00 00 05 (>4) or 00 00 00 00. Required:
  - no `load_*` pulses;
  - `tx_data`=0xEE;
  - return to IDLE;
  - a following valid image then loads normally.
- **Transmitter backpressure.** `tx_ready`=0 for 10 cycles after `load_end`. Required: `tx_valid`/0xAA held stable for those 10 cycles; `boot_done` rises the cycle after `tx_ready` goes to 1.
- **Reset mid-load.** `reset`=0 after 2 of 4 data bytes. Required:
  - all outputs return to their reset values the next cycle;
  - no `load_end`;
  - a fresh image after reset loads correctly.
- **Post-done ignore.** Send extra bytes in DONE. Required: no `load_*` or `tx_valid` activity; `boot_done` stays 1.
